// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller and the PC next-address selector.
package interrupt_controller_pkg;

   // Handler entry point loaded by the PC selector whenever INT pulses
   localparam logic [31:0] HANDLER_VECTOR = 32'h3020;

   // Default number of interrupt sources; the highest index has the highest priority
   localparam int NUM_SRC_DEFAULT = 3;

   // Controller state encoding: IDLE means no handler is active
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_SERVICE = 1'b1;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Highest-index-first priority encoder, used both to pick the request to take
// and to find the highest in-service level.
module prio_encoder #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [W-1:0] idx
);

   // Scan upward so the last set bit found, the highest index, wins
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latched requests, per-source masking, priority
// nesting with an EPC stack, and Eret-driven unwinding toward the PC selector.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_SRC    = NUM_SRC_DEFAULT,
   parameter int ADDR_BITS  = 32,
   parameter int DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    irq_req,
   input  logic                  mask_we,
   input  logic [NUM_SRC-1:0]    mask_wdata,
   input  logic                  global_en,
   input  logic                  int_allow,
   input  logic [ADDR_BITS-1:0]  pc_resume,
   input  logic                  Eret,
   output logic                  INT,
   output logic [ADDR_BITS-1:0]  EPC_out,
   output logic [NUM_SRC-1:0]    pending,
   output logic [NUM_SRC-1:0]    in_service,
   output logic [DEPTH_BITS-1:0] cur_src,
   output logic                  eret_err
);

   localparam int                    STACK_ENTRIES = 2 ** DEPTH_BITS;
   localparam logic [DEPTH_BITS-1:0] DEPTH_ONE     = DEPTH_BITS'(1);

   logic [NUM_SRC-1:0]    irq_dly;
   logic                  primed;
   logic [NUM_SRC-1:0]    mask;
   logic [DEPTH_BITS-1:0] depth;
   logic [DEPTH_BITS-1:0] top_idx;
   logic [ADDR_BITS-1:0]  stack [STACK_ENTRIES];
   logic [0:0]            state;

   logic [NUM_SRC-1:0]    rise;
   logic [NUM_SRC-1:0]    above;
   logic [NUM_SRC-1:0]    eligible;
   logic [NUM_SRC-1:0]    take_onehot;
   logic [NUM_SRC-1:0]    hp_onehot;
   logic                  hp_valid;
   logic [DEPTH_BITS-1:0] hp_idx;
   logic                  el_valid;
   logic [DEPTH_BITS-1:0] sel_idx;
   logic                  take;
   logic                  do_pop;

   prio_encoder #(.N(NUM_SRC), .W(DEPTH_BITS)) u_hp_enc (
      .req   (in_service),
      .valid (hp_valid),
      .idx   (hp_idx)
   );

   prio_encoder #(.N(NUM_SRC), .W(DEPTH_BITS)) u_sel_enc (
      .req   (eligible),
      .valid (el_valid),
      .idx   (sel_idx)
   );

   // The first clock after reset only reloads the delay register, so a line
   // already high when reset is released is not seen as a fresh edge
   assign rise     = primed ? (irq_req & ~irq_dly) : '0;
   assign eligible = pending & mask & above;
   assign take     = global_en & int_allow & ~Eret & el_valid;
   assign do_pop   = Eret & (depth != '0);
   assign top_idx  = depth - DEPTH_ONE;

   assign INT        = take;
   assign eret_err   = Eret & (depth == '0);
   assign EPC_out    = (depth == '0) ? '0 : stack[top_idx];
   assign cur_src    = hp_valid ? hp_idx : '0;

   // Per-source priority window above the active level, plus one-hot forms of
   // the selected request and the active level for set/clear updates
   always_comb begin
      above       = '0;
      take_onehot = '0;
      hp_onehot   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         above[i]       = !hp_valid || (i > int'(hp_idx));
         take_onehot[i] = take && (int'(sel_idx) == i);
         hp_onehot[i]   = hp_valid && (int'(hp_idx) == i);
      end
   end

   // Request latching, masking, and the push/pop of the nesting stack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_dly    <= '0;
         primed     <= 1'b0;
         mask       <= '0;
         pending    <= '0;
         in_service <= '0;
         depth      <= '0;
         for (int i = 0; i < STACK_ENTRIES; i++) begin
            stack[i] <= '0;
         end
      end else begin
         irq_dly <= irq_req;
         primed  <= 1'b1;
         if (mask_we) begin
            mask <= mask_wdata;
         end
         pending <= (pending & ~take_onehot) | rise;
         if (do_pop) begin
            depth      <= depth - DEPTH_ONE;
            in_service <= in_service & ~hp_onehot;
         end else if (take) begin
            in_service   <= in_service | take_onehot;
            stack[depth] <= pc_resume;
            depth        <= depth + DEPTH_ONE;
         end
      end
   end

   // IDLE/SERVICE tracking: leave SERVICE only when the last level unwinds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:    if (take) state <= ST_SERVICE;
            ST_SERVICE: if (do_pop && depth == DEPTH_ONE) state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller, checked against a
// stack-of-handlers reference model.
module tb_interrupt_controller;

   localparam int NUM = 3;

   typedef struct {
      int          src;
      logic [31:0] pc;
   } frame_t;

   logic           clk;
   logic           rst_n;
   logic [NUM-1:0] irqReq;
   logic           maskWe;
   logic [NUM-1:0] maskWdata;
   logic           globalEn;
   logic           intAllow;
   logic [31:0]    pcResume;
   logic           eret;
   logic           intOut;
   logic [31:0]    epcOut;
   logic [NUM-1:0] pendingOut;
   logic [NUM-1:0] inServiceOut;
   logic [1:0]     curSrc;
   logic           eretErr;

   int assertCount;
   int failCount;

   // Reference model state
   logic [NUM-1:0] mPend;
   logic [NUM-1:0] mMask;
   logic [NUM-1:0] mPrev;
   bit             mFirst;
   frame_t         mStack[$];

   interrupt_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_req    (irqReq),
      .mask_we    (maskWe),
      .mask_wdata (maskWdata),
      .global_en  (globalEn),
      .int_allow  (intAllow),
      .pc_resume  (pcResume),
      .Eret       (eret),
      .INT        (intOut),
      .EPC_out    (epcOut),
      .pending    (pendingOut),
      .in_service (inServiceOut),
      .cur_src    (curSrc),
      .eret_err   (eretErr)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int modelHp();
      return (mStack.size() == 0) ? -1 : mStack[mStack.size() - 1].src;
   endfunction

   // Highest pending, enabled request strictly above the active level
   function automatic int modelPick();
      int hp;
      hp = modelHp();
      for (int i = NUM - 1; i > hp; i--) begin
         if (mPend[i] && mMask[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit modelTake();
      return globalEn && intAllow && !eret && (modelPick() >= 0);
   endfunction

   task automatic modelReset();
      mPend  = '0;
      mMask  = '0;
      mPrev  = '0;
      mFirst = 1'b1;
      mStack.delete();
   endtask

   task automatic checkOutput();
      logic [NUM-1:0] expIs;
      logic [31:0]    expEpc;
      int             hp;
      expIs = '0;
      foreach (mStack[k]) expIs[mStack[k].src] = 1'b1;
      expEpc = (mStack.size() == 0) ? 32'h0 : mStack[mStack.size() - 1].pc;
      hp = modelHp();
      checkOne("INT",        {31'h0, intOut},       {31'h0, modelTake()});
      checkOne("EPC_out",    epcOut,                expEpc);
      checkOne("pending",    {29'h0, pendingOut},   {29'h0, mPend});
      checkOne("in_service", {29'h0, inServiceOut}, {29'h0, expIs});
      checkOne("cur_src",    {30'h0, curSrc},       (hp < 0) ? 32'h0 : hp);
      checkOne("eret_err",   {31'h0, eretErr},      {31'h0, (eret && mStack.size() == 0)});
   endtask

   task automatic modelUpdate();
      logic [NUM-1:0] r;
      int             s;
      frame_t         f;
      r = mFirst ? '0 : (irqReq & ~mPrev);
      s = modelPick();
      if (eret && mStack.size() != 0) begin
         void'(mStack.pop_back());
      end else if (modelTake()) begin
         mPend[s] = 1'b0;
         f.src = s;
         f.pc  = pcResume;
         mStack.push_back(f);
      end
      mPend  = mPend | r;
      mPrev  = irqReq;
      mFirst = 1'b0;
      if (maskWe) mMask = maskWdata;
   endtask

   // One cycle: drive at the falling edge, check settled outputs, advance the model on the rising edge
   task automatic applyStimulus(input logic [NUM-1:0] irq, input logic mwe, input logic [NUM-1:0] mwd,
                                input logic gen, input logic allow, input logic [31:0] pc, input logic er);
      @(negedge clk);
      irqReq    = irq;
      maskWe    = mwe;
      maskWdata = mwd;
      globalEn  = gen;
      intAllow  = allow;
      pcResume  = pc;
      eret      = er;
      #1;
      checkOutput();
      @(posedge clk);
      modelUpdate();
   endtask

   task automatic checkAllZero(input string tag);
      checkOne({tag, "_INT"},        {31'h0, intOut},       32'h0);
      checkOne({tag, "_EPC"},        epcOut,                32'h0);
      checkOne({tag, "_pending"},    {29'h0, pendingOut},   32'h0);
      checkOne({tag, "_in_service"}, {29'h0, inServiceOut}, 32'h0);
      checkOne({tag, "_cur_src"},    {30'h0, curSrc},       32'h0);
   endtask

   initial begin
      logic [NUM-1:0] rIrq;
      logic [NUM-1:0] rMask;
      assertCount = 0;
      failCount   = 0;
      rst_n     = 1'b0;
      irqReq    = '0;
      maskWe    = 1'b0;
      maskWdata = '0;
      globalEn  = 1'b0;
      intAllow  = 1'b0;
      pcResume  = '0;
      eret      = 1'b0;
      modelReset();
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic take of source 1, then nest source 2 and unwind
      applyStimulus(3'b000, 1, 3'b111, 1, 1, 32'h0,    0);
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h1008, 0);
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h1008, 0);
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h0,    0);
      checkOne("epc_1008", epcOut, 32'h1008);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h3040, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h3040, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0,    0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0,    1);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0,    1);
      applyStimulus(3'b000, 0, 3'b000, 1, 1, 32'h0,    0);

      // Lower-priority request waits until the active handler returns
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h2000, 0);
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h2000, 0);
      applyStimulus(3'b011, 0, 3'b000, 1, 1, 32'h2004, 0);
      applyStimulus(3'b011, 0, 3'b000, 1, 1, 32'h2008, 0);
      applyStimulus(3'b011, 0, 3'b000, 1, 1, 32'h0,    1);
      applyStimulus(3'b011, 0, 3'b000, 1, 1, 32'h200c, 0);
      applyStimulus(3'b000, 0, 3'b000, 1, 1, 32'h0,    1);

      // Masked source latches but waits for the mask write
      applyStimulus(3'b000, 1, 3'b011, 1, 1, 32'h0,    0);
      applyStimulus(3'b100, 0, 3'b000, 1, 1, 32'h4000, 0);
      applyStimulus(3'b100, 0, 3'b000, 1, 1, 32'h4000, 0);
      applyStimulus(3'b100, 1, 3'b111, 1, 1, 32'h4000, 0);
      applyStimulus(3'b100, 0, 3'b000, 1, 1, 32'h4004, 0);
      applyStimulus(3'b000, 0, 3'b000, 1, 1, 32'h0,    1);

      // Eret while idle, then Eret colliding with a takeable request
      applyStimulus(3'b000, 0, 3'b000, 1, 1, 32'h0,    1);
      applyStimulus(3'b001, 0, 3'b000, 1, 0, 32'h5000, 0);
      applyStimulus(3'b001, 0, 3'b000, 1, 1, 32'h5000, 1);
      applyStimulus(3'b001, 0, 3'b000, 1, 1, 32'h5004, 0);
      applyStimulus(3'b000, 0, 3'b000, 1, 1, 32'h0,    1);

      // Reach depth 2, then reset asynchronously between clock edges
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h6000, 0);
      applyStimulus(3'b010, 0, 3'b000, 1, 1, 32'h6000, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h6100, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h6100, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0, 0);
      applyStimulus(3'b110, 1, 3'b111, 1, 1, 32'h0, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0, 0);
      applyStimulus(3'b110, 0, 3'b000, 1, 1, 32'h0, 0);

      // Randomized traffic against the model
      rIrq  = 3'b110;
      rMask = 3'b111;
      for (int n = 0; n < 400; n++) begin
         logic mwe;
         logic er;
         for (int b = 0; b < NUM; b++) begin
            if ($urandom_range(5) == 0) rIrq[b] = ~rIrq[b];
         end
         mwe = ($urandom_range(9) == 0);
         if (mwe) rMask = NUM'($urandom_range(7)) | 3'b001;
         er = (mStack.size() != 0) ? ($urandom_range(4) == 0) : ($urandom_range(19) == 0);
         applyStimulus(rIrq, mwe, rMask, ($urandom_range(7) != 0), ($urandom_range(3) != 0),
                       $urandom, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
